// File: rtl/sr_bank_sync.sv
// sr_bank_sync: WIDTH SR flags with edge pulses and conflict tracking; SR_BANK_INPUT_SYNC_EN adds 2-flop input synchronisers
module sr_bank_sync #(
  parameter int WIDTH = 8,
  parameter int CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}},
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic             w_en;
  logic [WIDTH-1:0] w_cf;
  logic [WIDTH-1:0] w_cq;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_conflict;
  logic [CNT_W-1:0] r_cnt;

  if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
    $error("sr_bank_sync: CONFLICT_MODE must be 0..3");
  end

`ifdef SR_BANK_INPUT_SYNC_EN
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;
  logic             r_en1;
  logic             r_en2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_r1  <= '0;
      r_r2  <= '0;
      r_en1 <= 1'b0;
      r_en2 <= 1'b0;
    end else begin
      r_s1  <= s;
      r_s2  <= r_s1;
      r_r1  <= r;
      r_r2  <= r_r1;
      r_en1 <= en;
      r_en2 <= r_en1;
    end
  end
  assign w_s  = r_s2;
  assign w_r  = r_r2;
  assign w_en = r_en2;
`else
  assign w_s  = s;
  assign w_r  = r;
  assign w_en = en;
`endif

  // w_cq is the value a channel takes when S and R are both asserted
  always_comb begin
    w_cf   = {WIDTH{w_en}} & w_s & w_r;
    w_cq   = CONFLICT_MODE == 0 ? r_q :
             CONFLICT_MODE == 1 ? {WIDTH{1'b1}} :
             CONFLICT_MODE == 2 ? {WIDTH{1'b0}} : ~r_q;
    w_next = w_en ? (w_s & ~w_r) | (r_q & ~w_s & ~w_r) | (w_cf & w_cq) : r_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= INIT;
      r_qbar     <= ~INIT;
      r_rise     <= '0;
      r_fall     <= '0;
      r_conflict <= '0;
      r_cnt      <= '0;
    end else begin
      r_q        <= w_next;
      r_qbar     <= ~w_next;
      r_rise     <= w_next & ~r_q;
      r_fall     <= r_q & ~w_next;
      r_conflict <= (clr_conflict ? {WIDTH{1'b0}} : r_conflict) | w_cf;
      r_cnt      <= clr_conflict ? CNT_W'(|w_cf) :
                    (|w_cf && r_cnt != {CNT_W{1'b1}}) ? r_cnt + 1'b1 : r_cnt;
    end
  end

  assign q            = r_q;
  assign qbar         = r_qbar;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;
endmodule

// File: tb/tb_sr_bank_sync.sv
// tb_sr_bank_sync: four DUTs (one per CONFLICT_MODE) against a rule-table reference model
module tb_sr_bank_sync;
  localparam int W = 4;
  localparam int CW = 2;
  localparam logic [3:0] INIT = 4'b0101;
  logic clk = 1'b0;
  logic reset;
  logic en;
  logic clr_conflict;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] q_m [4];
  logic [3:0] qb_m [4];
  logic [3:0] ri_m [4];
  logic [3:0] fa_m [4];
  logic [3:0] cf_m [4];
  logic [1:0] cnt_m [4];
  int checks = 0;
  int errors = 0;
  logic [3:0] mq [4];
  logic [3:0] mri [4];
  logic [3:0] mfa [4];
  logic [3:0] mcf;
  int mcnt;
  logic [3:0] ps1, ps2, pr1, pr2;
  logic pe1, pe2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_bank_sync #(.WIDTH(W), .CONFLICT_MODE(g), .INIT(INIT), .CNT_W(CW)) u_dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .s(s),
      .r(r),
      .clr_conflict(clr_conflict),
      .q(q_m[g]),
      .qbar(qb_m[g]),
      .rise(ri_m[g]),
      .fall(fa_m[g]),
      .conflict(cf_m[g]),
      .conflict_cnt(cnt_m[g])
    );
  end

  task automatic model_step(input logic rs, input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
    logic [3:0] es, er, nq;
    logic ee;
    if (rs) begin
      for (int m = 0; m < 4; m++) begin
        mq[m] = INIT;
        mri[m] = 4'b0;
        mfa[m] = 4'b0;
      end
      mcf = 4'b0;
      mcnt = 0;
      {ps1, ps2, pr1, pr2, pe1, pe2} = '0;
      return;
    end
`ifdef SR_BANK_INPUT_SYNC_EN
    es = ps2; er = pr2; ee = pe2;
    ps2 = ps1; pr2 = pr1; pe2 = pe1;
    ps1 = sv; pr1 = rv; pe1 = e;
`else
    es = sv; er = rv; ee = e;
`endif
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) begin
        if (!ee || (!es[i] && !er[i])) nq[i] = mq[m][i];
        else if (es[i] != er[i]) nq[i] = es[i];
        else if (m == 0) nq[i] = mq[m][i];
        else if (m == 1) nq[i] = 1'b1;
        else if (m == 2) nq[i] = 1'b0;
        else nq[i] = !mq[m][i];
      end
      mri[m] = nq & ~mq[m];
      mfa[m] = mq[m] & ~nq;
      mq[m] = nq;
    end
    if (c) begin
      mcf = 4'b0;
      mcnt = 0;
    end
    if (ee && (es & er) != 4'b0) begin
      mcf = mcf | (es & er);
      mcnt = (mcnt + 1 > 3) ? 3 : mcnt + 1;
    end
  endtask

  task automatic cyc(input logic rs, input logic e, input logic [3:0] sv, input logic [3:0] rv, input logic c);
    reset = rs;
    en = e;
    s = sv;
    r = rv;
    clr_conflict = c;
    @(posedge clk);
    model_step(rs, e, sv, rv, c);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_m[m] !== 4'b0101 || qb_m[m] !== 4'b1010 || ri_m[m] !== 4'b0 || fa_m[m] !== 4'b0 || cf_m[m] !== 4'b0 || cnt_m[m] !== 2'd0) begin
        errors++;
        $display("FAIL reset mode %0d: q=%b qbar=%b rise=%b fall=%b cf=%b cnt=%0d want 0101 1010 0 0 0 0", m, q_m[m], qb_m[m], ri_m[m], fa_m[m], cf_m[m], cnt_m[m]);
      end
    end
  endtask

`ifndef SR_BANK_INPUT_SYNC_EN
  task automatic test_set_reset();
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b1000, 4'b0001, 1'b0);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_m[m] !== 4'b1100 || qb_m[m] !== 4'b0011 || ri_m[m] !== 4'b1000 || fa_m[m] !== 4'b0001) begin
        errors++;
        $display("FAIL set_reset mode %0d: q=%b qbar=%b rise=%b fall=%b want 1100 0011 1000 0001", m, q_m[m], qb_m[m], ri_m[m], fa_m[m]);
      end
    end
    cyc(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_m[m] !== 4'b1100 || ri_m[m] !== 4'b0 || fa_m[m] !== 4'b0) begin
        errors++;
        $display("FAIL en_low_hold mode %0d: q=%b rise=%b fall=%b want 1100 0 0", m, q_m[m], ri_m[m], fa_m[m]);
      end
    end
  endtask

  task automatic test_conflict_modes();
    logic [3:0] e1 [4];
    logic [3:0] e2 [4];
    e1 = '{4'b0101, 4'b0111, 4'b0100, 4'b0110};
    e2 = '{4'b0101, 4'b0111, 4'b0100, 4'b0101};
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_m[m] !== e1[m] || cf_m[m] !== 4'b0011 || cnt_m[m] !== 2'd1) begin
        errors++;
        $display("FAIL conflict_mode first mode %0d: q=%b cf=%b cnt=%0d want %b 0011 1", m, q_m[m], cf_m[m], cnt_m[m], e1[m]);
      end
    end
    cyc(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (q_m[m] !== e2[m]) begin
        errors++;
        $display("FAIL conflict_mode second mode %0d: q=%b want %b", m, q_m[m], e2[m]);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
      checks++;
      if (cnt_m[0] !== 2'(exp_cnt[k]) || cf_m[0] !== 4'b0001) begin
        errors++;
        $display("FAIL saturation step %0d: cnt=%0d cf=%b want %0d 0001", k, cnt_m[0], cf_m[0], exp_cnt[k]);
      end
    end
    cyc(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
    checks++;
    if (cnt_m[0] !== 2'd0 || cf_m[0] !== 4'b0) begin
      errors++;
      $display("FAIL clr_conflict: cnt=%0d cf=%b want 0 0000", cnt_m[0], cf_m[0]);
    end
  endtask

  task automatic test_clr_and_conflict();
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    cyc(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    cyc(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (cf_m[m] !== 4'b0100 || cnt_m[m] !== 2'd1) begin
        errors++;
        $display("FAIL clr_with_conflict mode %0d: cf=%b cnt=%0d want 0100 1", m, cf_m[m], cnt_m[m]);
      end
    end
  endtask
`else
  task automatic test_sync();
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b0010, 4'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    checks++;
    if (q_m[0] !== 4'b0101) begin
      errors++;
      $display("FAIL sync_early: q=%b want 0101", q_m[0]);
    end
    cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    checks++;
    if (q_m[0] !== 4'b0111 || ri_m[0] !== 4'b0010) begin
      errors++;
      $display("FAIL sync_latency: q=%b rise=%b want 0111 0010", q_m[0], ri_m[0]);
    end
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'b0010, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      checks++;
      if (q_m[0] !== 4'b0101 || ri_m[0] !== 4'b0) begin
        errors++;
        $display("FAIL sync_reset_discard step %0d: q=%b rise=%b want 0101 0000", k, q_m[0], ri_m[0]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(31) == 0, $urandom_range(3) != 0, 4'($urandom), 4'($urandom), $urandom_range(7) == 0);
      for (int m = 0; m < 4; m++) begin
        checks++;
        if (q_m[m] !== mq[m] || qb_m[m] !== ~mq[m] || ri_m[m] !== mri[m] || fa_m[m] !== mfa[m] || cf_m[m] !== mcf || cnt_m[m] !== 2'(mcnt)) begin
          errors++;
          $display("FAIL random cyc %0d mode %0d: q=%b/%b qbar=%b rise=%b/%b fall=%b/%b cf=%b/%b cnt=%0d/%0d (got/want)",
                   n, m, q_m[m], mq[m], qb_m[m], ri_m[m], mri[m], fa_m[m], mfa[m], cf_m[m], mcf, cnt_m[m], mcnt);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    s = 4'h0;
    r = 4'h0;
    clr_conflict = 1'b0;
    test_reset();
`ifndef SR_BANK_INPUT_SYNC_EN
    test_set_reset();
    test_conflict_modes();
    test_saturation();
    test_clr_and_conflict();
`else
    test_sync();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_bank_sync.md
Name: sr_bank_sync

Overview:
- Parametrised bank of WIDTH independent SR storage elements sharing one clock and one synchronous, active-high reset.
- Conflict resolution (S and R both high) is selectable by parameter; the outputs never go to X.
- Also provides per-channel rise/fall event pulses, a sticky per-channel conflict flag and a saturating conflict-cycle counter.
- Used wherever control/status latching of many flags is needed, e.g. interrupt-pending and error-status registers.

Parameters:
- WIDTH, 8, number of SR channels (>=1)
- CONFLICT_MODE, 0, S=R=1 resolution: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle
- INIT, {WIDTH{1'b0}}, reset value of q
- CNT_W, 8, width of conflict_cnt (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- en  in  1  update enable; when low, all channels hold
- s  in  WIDTH  per-channel set
- r  in  WIDTH  per-channel reset
- clr_conflict  in  1  clears conflict flags and counter
- q  out  WIDTH  stored state
- qbar  out  WIDTH  always exactly ~q
- rise  out  WIDTH  one-cycle pulse when q[i] goes 0->1
- fall  out  WIDTH  one-cycle pulse when q[i] goes 1->0
- conflict  out  WIDTH  sticky flag, set when s[i]&r[i]&en sampled
- conflict_cnt  out  CNT_W  saturating count of cycles with any sampled conflict

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high, sampled on rising clk edge.
- Reset values, taking effect the cycle after reset is sampled high:
  - q=INIT, qbar=~INIT
  - rise=0, fall=0
  - conflict=0, conflict_cnt=0
- Reset has priority over en, s, r and clr_conflict.
- Update rule, per channel i, registered, 1-cycle latency from sampled inputs:
  - en=0: q[i] holds; rise/fall=0; conflict logic sees no conflict.
  - en=1, s=0, r=0: hold.
  - en=1, s=0, r=1: q[i]=0.
  - en=1, s=1, r=0: q[i]=1.
  - en=1, s=1, r=1, by CONFLICT_MODE:
    - 0: hold
    - 1: q[i]=1
    - 2: q[i]=0
    - 3: q[i]=~q[i]
    - any other value is illegal and must fail elaboration.
- qbar is registered alongside q; there is no cycle in which qbar != ~q.
- Event pulses:
  - rise[i]/fall[i] are registered and asserted in the same cycle the new q[i] value appears, for exactly one cycle.
  - Repeated set while q[i]=1 gives no pulse.
  - A reset that changes q[i] gives no pulse; rise/fall are forced 0 in the reset cycle.
- Conflict tracking:
  - conflict[i] sets on any sampled en&s[i]&r[i] and stays set until clr_conflict or reset.
  - conflict_cnt increments by 1 per cycle in which any channel has en&s&r, regardless of how many channels conflict.
  - conflict_cnt saturates at 2^CNT_W-1; there is no wrap.
- clr_conflict and a new conflict in the same cycle: the new conflict wins.
  - conflict = that cycle's conflict vector.
  - conflict_cnt = 1.
- Reset asserted mid-operation: the state of every register is discarded the next cycle; no partial update.

Optional Feature:
- Macro: SR_BANK_INPUT_SYNC_EN.
- Defined:
  - s, r and en each pass through a 2-flop synchroniser (reset to 0) before the update logic.
  - Input-to-q latency becomes 3 cycles.
  - The synchroniser flops clear on reset.
- Undefined:
  - No synchroniser; latency is 1 cycle.
  - Inputs must be synchronous to clk.

Test Plan (WIDTH=4, INIT=4'b0101, CNT_W=2, macro undefined unless noted):
1. Reset: hold reset=1 with s=4'hF, en=1 -> next cycle q=4'b0101, qbar=4'b1010, conflict=0, conflict_cnt=0, rise=fall=0.
2. Basic set/reset: en=1, s=4'b1000, r=4'b0001 for one cycle -> q=4'b1100, rise=4'b1000 and fall=4'b0001 for one cycle only; en=0 with s=4'hF -> q unchanged.
3. Conflict modes: s=r=4'b0011, en=1 on q=4'b0101:
   - mode 0 -> q=4'b0101
   - mode 1 -> q=4'b0111
   - mode 2 -> q=4'b0100
   - mode 3 -> q=4'b0110, then the same stimulus again -> 4'b0101
4. Counter saturation: 5 consecutive conflict cycles -> conflict_cnt 1,2,3,3,3; clr_conflict with no conflict -> conflict=0, cnt=0.
5. Simultaneous clr_conflict and conflict on channel 2 -> conflict=4'b0100, conflict_cnt=1.
6. With SR_BANK_INPUT_SYNC_EN defined: s=4'b0010 pulsed at cycle 0 -> q[1]=1 and rise[1]=1 at cycle 3; reset at cycle 1 -> q returns to INIT and the pending set is discarded.
